// File: rtl/piso_serializer_pkg.sv
// piso_serializer_pkg
//   Shared definitions for piso_frame_serializer: the frame FSM state
//   encoding, the fixed start/stop bit lengths and a helper that gives the
//   total frame length in clock cycles.
package piso_serializer_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  localparam int START_BIT_CYCLES = 1;
  localparam int STOP_BIT_CYCLES  = 1;

  // Cycles from the first start-bit cycle to the last stop-bit cycle.
  function automatic int frame_length(input int width, input bit parity_en);
    return START_BIT_CYCLES + width + STOP_BIT_CYCLES + (parity_en ? 1 : 0);
  endfunction

endpackage

// File: rtl/piso_frame_serializer.sv
// piso_frame_serializer
//   Accepts parallel words over a valid/ready handshake and sends each one
//   as a framed serial stream, one bit per clock:
//     start bit (~IDLE_LEVEL), DATA_WIDTH payload bits, [parity], stop bit.
//   Serial_Data_Out is registered and feeds the downstream SISO shift
//   register directly on the same clock.
//
//   Build option: define PISO_FRAME_SERIALIZER_PARITY_EN to insert an even
//   parity bit (XOR of the latched word) between payload and stop bit.
//
//   Ports
//     Clk_In            in   system clock, rising edge
//     Reset_In          in   synchronous active-high reset
//     Parallel_Data_In  in   [DATA_WIDTH] word, sampled only on handshake
//     Data_Valid_In     in   upstream offers a word
//     Data_Ready_Out    out  word can be accepted this cycle (combinational)
//     Serial_Data_Out   out  registered serial line
//     Busy_Out          out  FSM is not IDLE
//     Frame_Done_Out    out  high for the cycle the stop bit is on the line
module piso_frame_serializer
  import piso_serializer_pkg::*;
#(
  parameter int   DATA_WIDTH = 8,
  parameter int   LSB_FIRST  = 1,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic                  Clk_In,
  input  logic                  Reset_In,
  input  logic [DATA_WIDTH-1:0] Parallel_Data_In,
  input  logic                  Data_Valid_In,
  output logic                  Data_Ready_Out,
  output logic                  Serial_Data_Out,
  output logic                  Busy_Out,
  output logic                  Frame_Done_Out
);

  localparam int              CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  state_e                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [DATA_WIDTH-1:0]   shreg_q;
  logic [DATA_WIDTH-1:0]   shreg_d;
  logic                    data_bit;
  logic                    sdo_q;
  logic                    done_q;
  logic                    xfer;
`ifdef PISO_FRAME_SERIALIZER_PARITY_EN
  logic                    par_q;
`endif

  // STOP may accept the next word so frames run back-to-back, but not while
  // reset is being applied on this edge.
  assign Data_Ready_Out  = (state_q == IDLE) || ((state_q == STOP) && !Reset_In);
  assign xfer            = Data_Valid_In && Data_Ready_Out;
  assign Busy_Out        = (state_q != IDLE);
  assign Serial_Data_Out = sdo_q;
  assign Frame_Done_Out  = done_q;

  // The bit on the outgoing end of the shift register and the shifted value.
  always_comb begin
    if (LSB_FIRST != 0) begin
      data_bit = shreg_q[0];
      shreg_d  = {1'b0, shreg_q[DATA_WIDTH-1:1]};
    end else begin
      data_bit = shreg_q[DATA_WIDTH-1];
      shreg_d  = {shreg_q[DATA_WIDTH-2:0], 1'b0};
    end
  end

  // Outputs are registered from the current state, so the line shows a
  // state's bit during the cycle after that state is entered.
  always_ff @(posedge Clk_In) begin
    if (Reset_In) begin
      state_q <= IDLE;
      sdo_q   <= IDLE_LEVEL;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      shreg_q <= '0;
`ifdef PISO_FRAME_SERIALIZER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (xfer) begin
        shreg_q <= Parallel_Data_In;
`ifdef PISO_FRAME_SERIALIZER_PARITY_EN
        par_q   <= ^Parallel_Data_In;
`endif
      end
      case (state_q)
        IDLE: begin
          sdo_q <= IDLE_LEVEL;
          if (xfer) state_q <= START;
        end
        START: begin
          sdo_q   <= ~IDLE_LEVEL;
          cnt_q   <= '0;
          state_q <= DATA;
        end
        DATA: begin
          sdo_q   <= data_bit;
          shreg_q <= shreg_d;
          // Hold the counter on the last bit so it never wraps in a frame.
          if (cnt_q == LAST_BIT) begin
`ifdef PISO_FRAME_SERIALIZER_PARITY_EN
            state_q <= PARITY;
`else
            state_q <= STOP;
`endif
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`ifdef PISO_FRAME_SERIALIZER_PARITY_EN
        PARITY: begin
          sdo_q   <= par_q;
          state_q <= STOP;
        end
`endif
        STOP: begin
          sdo_q   <= IDLE_LEVEL;
          done_q  <= 1'b1;
          state_q <= xfer ? START : IDLE;
        end
        default: begin
          sdo_q   <= IDLE_LEVEL;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_frame_serializer.sv
// tb_piso_frame_serializer
//   Directed bench for piso_frame_serializer. Two instances share the clock:
//   u_lsb (LSB_FIRST=1) carries most scenarios, u_msb (LSB_FIRST=0) the
//   MSB-first frame. Expected line streams are written out by hand, first
//   transmitted bit at the left; the parity build uses the 11-bit variants.
module tb_piso_frame_serializer;

`ifdef PISO_FRAME_SERIALIZER_PARITY_EN
  localparam int FL = 11;
  localparam logic [FL-1:0] F_A5  = 11'b01010010101;
  localparam logic [FL-1:0] F_01  = 11'b01000000011;
  localparam logic [FL-1:0] F_FF  = 11'b01111111101;
  localparam logic [FL-1:0] F_00  = 11'b00000000001;
  localparam logic [FL-1:0] F_55  = 11'b01010101001;
  localparam logic [FL-1:0] F_M80 = 11'b01000000011;
`else
  localparam int FL = 10;
  localparam logic [FL-1:0] F_A5  = 10'b0101001011;
  localparam logic [FL-1:0] F_01  = 10'b0100000001;
  localparam logic [FL-1:0] F_FF  = 10'b0111111111;
  localparam logic [FL-1:0] F_00  = 10'b0000000001;
  localparam logic [FL-1:0] F_55  = 10'b0101010101;
  localparam logic [FL-1:0] F_M80 = 10'b0100000001;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] lsb_data, msb_data;
  logic       lsb_valid, msb_valid;
  logic       lsb_ready, lsb_sdo, lsb_busy, lsb_done;
  logic       msb_ready, msb_sdo, msb_busy, msb_done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  piso_frame_serializer #(.DATA_WIDTH(8), .LSB_FIRST(1), .IDLE_LEVEL(1'b1)) u_lsb (
    .Clk_In(clk), .Reset_In(rst), .Parallel_Data_In(lsb_data),
    .Data_Valid_In(lsb_valid), .Data_Ready_Out(lsb_ready),
    .Serial_Data_Out(lsb_sdo), .Busy_Out(lsb_busy), .Frame_Done_Out(lsb_done)
  );

  piso_frame_serializer #(.DATA_WIDTH(8), .LSB_FIRST(0), .IDLE_LEVEL(1'b1)) u_msb (
    .Clk_In(clk), .Reset_In(rst), .Parallel_Data_In(msb_data),
    .Data_Valid_In(msb_valid), .Data_Ready_Out(msb_ready),
    .Serial_Data_Out(msb_sdo), .Busy_Out(msb_busy), .Frame_Done_Out(msb_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Follows one frame on u_lsb for FL cycles after its accepting edge.
  // mode=1: valid toggles during the frame (must be ignored) and is high in
  // STOP, so the next word is accepted back-to-back.
  task automatic check_frame(input logic [FL-1:0] exp, input string tag, input bit mode);
    logic [FL-1:0] v;
    v = exp;
    for (int i = 1; i <= FL; i++) begin
      tick();
      chk($sformatf("%s line[%0d]", tag, i), lsb_sdo, v[FL-i]);
      chk($sformatf("%s done[%0d]", tag, i), lsb_done, (i == FL));
      chk($sformatf("%s busy[%0d]", tag, i), lsb_busy, (i < FL) ? 1'b1 : logic'(mode));
      chk($sformatf("%s ready[%0d]", tag, i), lsb_ready,
          (i == FL - 1) ? 1'b1 : ((i == FL) ? logic'(!mode) : 1'b0));
      if (mode) lsb_valid = (i >= FL - 1) ? 1'b1 : logic'(i[0]);
      else      lsb_valid = 1'b0;
    end
  endtask

  initial begin
    rst       = 1'b1;
    lsb_valid = 1'b0;
    msb_valid = 1'b0;
    lsb_data  = 8'h00;
    msb_data  = 8'h00;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst line", lsb_sdo, 1'b1);
    chk("rst busy", lsb_busy, 1'b0);
    chk("rst done", lsb_done, 1'b0);
    chk("rst ready", lsb_ready, 1'b1);
    chk("rst msb line", msb_sdo, 1'b1);

    // Single word 8'hA5, valid for one cycle
    lsb_data  = 8'hA5;
    lsb_valid = 1'b1;
    tick();
    lsb_valid = 1'b0;
    check_frame(F_A5, "a5", 1'b0);

    // 8'h01 then 8'hA5 (parity 1 then 0 in the parity build)
    lsb_data  = 8'h01;
    lsb_valid = 1'b1;
    tick();
    lsb_valid = 1'b0;
    check_frame(F_01, "01", 1'b0);
    lsb_data  = 8'hA5;
    lsb_valid = 1'b1;
    tick();
    lsb_valid = 1'b0;
    check_frame(F_A5, "a5b", 1'b0);

    // Back-to-back 8'hFF then 8'h00; input word changes mid-frame
    lsb_data  = 8'hFF;
    lsb_valid = 1'b1;
    tick();
    lsb_data  = 8'h00;
    check_frame(F_FF, "ff", 1'b1);
    check_frame(F_00, "00", 1'b0);

    // Valid toggling with 8'h55 while 8'hA5 is in flight
    lsb_data  = 8'hA5;
    lsb_valid = 1'b1;
    tick();
    lsb_data  = 8'h55;
    check_frame(F_A5, "a5tog", 1'b1);
    check_frame(F_55, "55", 1'b0);

    // Reset pulse in the middle of 8'h3C's payload
    lsb_data  = 8'h3C;
    lsb_valid = 1'b1;
    tick();
    lsb_valid = 1'b0;
    tick(); chk("3c start", lsb_sdo, 1'b0);
    tick(); chk("3c bit0", lsb_sdo, 1'b0);
    tick(); chk("3c bit1", lsb_sdo, 1'b0);
    tick(); chk("3c bit2", lsb_sdo, 1'b1);
    rst = 1'b1;
    #1;
    chk("3c ready in rst", lsb_ready, 1'b0);
    tick();
    rst = 1'b0;
    chk("3c rst line", lsb_sdo, 1'b1);
    chk("3c rst busy", lsb_busy, 1'b0);
    chk("3c rst done", lsb_done, 1'b0);
    chk("3c rst ready", lsb_ready, 1'b1);
    for (int i = 0; i < FL + 2; i++) begin
      tick();
      chk($sformatf("3c idle done[%0d]", i), lsb_done, 1'b0);
      chk($sformatf("3c idle line[%0d]", i), lsb_sdo, 1'b1);
    end

    // MSB-first 8'h80 on the second instance
    begin
      logic [FL-1:0] v;
      v = F_M80;
      msb_data  = 8'h80;
      msb_valid = 1'b1;
      chk("m80 ready", msb_ready, 1'b1);
      tick();
      msb_valid = 1'b0;
      for (int i = 1; i <= FL; i++) begin
        tick();
        chk($sformatf("m80 line[%0d]", i), msb_sdo, v[FL-i]);
        chk($sformatf("m80 done[%0d]", i), msb_done, (i == FL));
        chk($sformatf("m80 busy[%0d]", i), msb_busy, (i < FL));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
